sram_to_sram_run_ctrl: RTL and testbench

//  Run sequencer for the SRAM-to-SRAM multiply/accumulate core.

---
 rtl/sram_to_sram_run_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_to_sram_run_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_to_sram_run_ctrl.sv
`timescale 1ns/1ps
// Purpose: run sequencer for the SRAM-to-SRAM MAC core; fires N core passes per command, returns one response beat.
// Latency: core_start one cycle after accept; next core_start one cycle after core_done (gap=0) or gap+1 cycles later.
// Backpressure: s_cmd_ready only in IDLE; response beat held with stable fields until m_rsp_ready; cke=0 freezes everything.
//
// Ports: reset_n/clk/cke        async active-low reset, clock, clock enable
//        s_cmd_count/gap/valid/ready   command channel (run count, inter-run idle gap)
//        abort                  level, sticky; current pass always finishes
//        core_start/core_done   one-cycle pulses to/from the core
//        busy                   high outside IDLE
//        m_rsp_runs/timeout/aborted/valid/ready   response channel
//        perf_cycles            sequence cycle count (START/WAIT/GAP cycles)
// Option: define SRAM_TO_SRAM_RUN_CTRL_PERF_EN to build the perf counter; otherwise perf_cycles is tied to 0.
module sram_to_sram_run_ctrl #(
    parameter int RUN_BITS       = 8,
    parameter int GAP_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                reset_n,
    input  logic                clk,
    input  logic                cke,
    input  logic [RUN_BITS-1:0] s_cmd_count,
    input  logic [GAP_BITS-1:0] s_cmd_gap,
    input  logic                s_cmd_valid,
    output logic                s_cmd_ready,
    input  logic                abort,
    output logic                core_start,
    input  logic                core_done,
    output logic                busy,
    output logic [RUN_BITS-1:0] m_rsp_runs,
    output logic                m_rsp_timeout,
    output logic                m_rsp_aborted,
    output logic                m_rsp_valid,
    input  logic                m_rsp_ready,
    output logic [31:0]         perf_cycles
);

    localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    state_t              state;
    logic [RUN_BITS-1:0] count_q;
    logic [RUN_BITS-1:0] runs_q;
    logic [RUN_BITS-1:0] runs_inc;
    logic [GAP_BITS-1:0] gap_q;
    logic [GAP_BITS-1:0] gap_cnt;
    logic [TMR_BITS-1:0] timer;
    logic                abort_flag;
    logic                abort_seen;

    // An abort arriving in the same cycle as a decision point counts immediately.
    assign abort_seen  = abort_flag | abort;
    assign runs_inc    = runs_q + 1'b1;
    assign s_cmd_ready = (state == S_IDLE);
    assign m_rsp_runs  = runs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            count_q       <= '0;
            runs_q        <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            timer         <= '0;
            abort_flag    <= 1'b0;
            core_start    <= 1'b0;
            busy          <= 1'b0;
            m_rsp_timeout <= 1'b0;
            m_rsp_aborted <= 1'b0;
            m_rsp_valid   <= 1'b0;
        end else if (cke) begin
            case (state)
                S_IDLE: begin
                    if (s_cmd_valid) begin
                        count_q       <= s_cmd_count;
                        gap_q         <= s_cmd_gap;
                        runs_q        <= '0;
                        abort_flag    <= 1'b0;
                        m_rsp_timeout <= 1'b0;
                        m_rsp_aborted <= 1'b0;
                        busy          <= 1'b1;
                        if (s_cmd_count == '0) begin
                            state       <= S_RESP;
                            m_rsp_valid <= 1'b1;
                        end else begin
                            state      <= S_START;
                            core_start <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    timer      <= '0;
                    state      <= S_WAIT;
                    if (abort) abort_flag <= 1'b1;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (abort) abort_flag <= 1'b1;
                    // done takes priority over a timeout landing in the same cycle
                    if (core_done) begin
                        runs_q <= runs_inc;
                        if ((runs_inc == count_q) || abort_seen) begin
                            state         <= S_RESP;
                            m_rsp_valid   <= 1'b1;
                            m_rsp_aborted <= abort_seen && (runs_inc < count_q);
                        end else if (gap_q == '0) begin
                            state      <= S_START;
                            core_start <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end else if (timer == TMR_LAST) begin
                        // runs < count always holds while still waiting on a pass
                        state         <= S_RESP;
                        m_rsp_valid   <= 1'b1;
                        m_rsp_timeout <= 1'b1;
                        m_rsp_aborted <= abort_seen;
                    end
                end
                S_GAP: begin
                    if (abort_seen) begin
                        abort_flag    <= 1'b1;
                        state         <= S_RESP;
                        m_rsp_valid   <= 1'b1;
                        m_rsp_aborted <= 1'b1;
                    end else if (gap_cnt == gap_q - 1'b1) begin
                        state      <= S_START;
                        core_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (m_rsp_ready) begin
                        m_rsp_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_TO_SRAM_RUN_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (cke) begin
            if ((state == S_IDLE) && s_cmd_valid) begin
                perf_q <= '0;
            end else if (((state == S_START) || (state == S_WAIT) || (state == S_GAP)) &&
                         (perf_q != 32'hFFFF_FFFF)) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sram_to_sram_run_ctrl.sv
`timescale 1ns/1ps
// Purpose: directed scoreboard bench for sram_to_sram_run_ctrl with a behavioural core model.
// Latency: core model raises core_done a programmable number of enabled cycles after core_start.
// Backpressure: m_rsp_ready driven per step; cke gates both the DUT and the core model.
module tb_sram_to_sram_run_ctrl;

    typedef struct packed {
        logic [7:0] runs;
        logic       timeout;
        logic       aborted;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1;
    logic [7:0]  s_cmd_count = '0;
    logic [7:0]  s_cmd_gap = '0;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic        abort = 1'b0;
    logic        core_start;
    logic        core_done;
    logic        busy;
    logic [7:0]  m_rsp_runs;
    logic        m_rsp_timeout;
    logic        m_rsp_aborted;
    logic        m_rsp_valid;
    logic        m_rsp_ready = 1'b1;
    logic [31:0] perf_cycles;

    sram_to_sram_run_ctrl #(
        .RUN_BITS       (8),
        .GAP_BITS       (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .reset_n       (reset_n),
        .clk           (clk),
        .cke           (cke),
        .s_cmd_count   (s_cmd_count),
        .s_cmd_gap     (s_cmd_gap),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .abort         (abort),
        .core_start    (core_start),
        .core_done     (core_done),
        .busy          (busy),
        .m_rsp_runs    (m_rsp_runs),
        .m_rsp_timeout (m_rsp_timeout),
        .m_rsp_aborted (m_rsp_aborted),
        .m_rsp_valid   (m_rsp_valid),
        .m_rsp_ready   (m_rsp_ready),
        .perf_cycles   (perf_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model plus start/done monitor, evaluated on the falling edge.
    int core_lat = 10;
    bit core_hang = 1'b0;
    int rem = 0;
    bit core_busy = 1'b0;
    int n_starts = 0;
    int n_dones = 0;
    int last_done = 0;
    int last_start = 0;
    int deltas[$];

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem       = 0;
            core_busy = 1'b0;
            core_done = 1'b0;
        end else if (cke) begin
            if (core_start) begin
                n_starts++;
                deltas.push_back(cyc - last_done);
                last_start = cyc;
            end
            core_done = 1'b0;
            if (core_busy) begin
                rem = rem - 1;
                if (rem == 0) begin
                    core_busy = 1'b0;
                    core_done = 1'b1;
                end
            end
            if (core_start) begin
                core_busy = !core_hang;
                rem       = core_lat;
            end
            if (core_done) begin
                n_dones++;
                last_done = cyc;
            end
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   rsp_cyc = 0;
    rsp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_perf(input string tag, input int exp_val);
        int e;
        e = exp_val;
`ifndef SRAM_TO_SRAM_RUN_CTRL_PERF_EN
        e = 0;
`endif
        chk(tag, perf_cycles, e);
    endtask

    task automatic send_cmd(input int cnt, input int gp, input bit push,
                            input int er, input bit et, input bit ea);
        int w;
        rsp_t e;
        w = 0;
        while (!s_cmd_ready && w < 50) begin
            tick(1);
            w++;
        end
        chk("cmd_ready_before_send", s_cmd_ready, 1);
        s_cmd_count = 8'(cnt);
        s_cmd_gap   = 8'(gp);
        s_cmd_valid = 1'b1;
        if (push) begin
            e.runs    = 8'(er);
            e.timeout = et;
            e.aborted = ea;
            exp_q.push_back(e);
        end
        tick(1);
        s_cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int w;
        w = 0;
        while (n_starts < target && w < budget) begin
            tick(1);
            w++;
        end
        chk("wait_core_start", n_starts >= target, 1);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int w;
        w = 0;
        while (n_dones < target && w < budget) begin
            tick(1);
            w++;
        end
        chk("wait_core_done", n_dones >= target, 1);
    endtask

    // Waits for the response beat, compares it with the scoreboard head,
    // optionally holds ready low for 'hold' cycles, then completes the handshake.
    task automatic wait_rsp(input string tag, input int budget, input int hold);
        int   w;
        bit   ok;
        rsp_t e;
        rsp_t got;
        w = 0;
        @(negedge clk);
        while (!m_rsp_valid && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_rsp_valid"}, m_rsp_valid, 1);
        rsp_cyc = cyc;
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        got = {m_rsp_runs, m_rsp_timeout, m_rsp_aborted};
        chk({tag, "_runs"}, got.runs, e.runs);
        chk({tag, "_timeout"}, got.timeout, e.timeout);
        chk({tag, "_aborted"}, got.aborted, e.aborted);
        if (hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!m_rsp_valid || s_cmd_ready ||
                    ({m_rsp_runs, m_rsp_timeout, m_rsp_aborted} !== got)) ok = 1'b0;
            end
            chk({tag, "_hold_stable"}, ok, 1);
            m_rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_ready_after_hs"}, s_cmd_ready, 1);
        chk({tag, "_busy_after_hs"}, busy, 0);
    endtask

    initial begin
        int base;
        int base_d;
        bit ok;

        // Reset state
        tick(3);
        chk("rst_core_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", m_rsp_valid, 0);
        chk("rst_rsp_runs", m_rsp_runs, 0);
        chk("rst_rsp_timeout", m_rsp_timeout, 0);
        chk("rst_rsp_aborted", m_rsp_aborted, 0);
        chk("rst_perf", perf_cycles, 0);
        reset_n = 1'b1;
        tick(2);
        chk("rst_cmd_ready", s_cmd_ready, 1);

        // count=3, gap=0: starts one cycle after each done
        base = n_starts;
        core_lat = 10;
        send_cmd(3, 0, 1'b1, 3, 1'b0, 1'b0);
        chk("b2b_busy", busy, 1);
        wait_rsp("b2b", 200, 0);
        chk("b2b_starts", n_starts - base, 3);
        chk("b2b_delta1", deltas[base + 1], 1);
        chk("b2b_delta2", deltas[base + 2], 1);
        chk_perf("b2b_perf", 3 * 11);

        // count=2, gap=5: five idle cycles between done and next start
        base = n_starts;
        send_cmd(2, 5, 1'b1, 2, 1'b0, 1'b0);
        wait_rsp("gap", 200, 0);
        chk("gap_starts", n_starts - base, 2);
        chk("gap_delta", deltas[base + 1], 6);
        chk_perf("gap_perf", 2 * 11 + 5);

        // count=0: no start, immediate response
        base = n_starts;
        send_cmd(0, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("zero_cmd_ready_low", s_cmd_ready, 0);
        chk("zero_busy", busy, 1);
        wait_rsp("zero", 2, 0);
        chk("zero_starts", n_starts - base, 0);

        // Core never done: timeout after 16 WAIT cycles
        core_hang = 1'b1;
        send_cmd(1, 0, 1'b1, 0, 1'b1, 1'b0);
        wait_rsp("tmo", 100, 0);
        chk("tmo_latency", rsp_cyc - last_start, 17);
        core_hang = 1'b0;

        // Done on the last WAIT cycle wins over timeout
        core_lat = 16;
        send_cmd(1, 0, 1'b1, 1, 1'b0, 1'b0);
        wait_rsp("edge", 100, 0);
        chk("edge_latency", rsp_cyc - last_start, 17);

        // Abort during pass 2 WAIT: pass 2 completes, no third start
        core_lat = 10;
        base = n_starts;
        send_cmd(5, 0, 1'b1, 2, 1'b0, 1'b1);
        wait_starts(base + 2, 100);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_rsp("abw", 200, 0);
        chk("abw_starts", n_starts - base, 2);

        // Abort during GAP: no further start
        core_lat = 4;
        base = n_starts;
        base_d = n_dones;
        send_cmd(5, 8, 1'b1, 1, 1'b0, 1'b1);
        wait_dones(base_d + 1, 100);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_rsp("abg", 100, 0);
        chk("abg_starts", n_starts - base, 1);

        // Response backpressure: ready low for 20 cycles
        core_lat = 3;
        m_rsp_ready = 1'b0;
        send_cmd(1, 0, 1'b1, 1, 1'b0, 1'b0);
        wait_rsp("hold", 100, 20);

        // cke low for 8 cycles in WAIT: timer frozen, no timeout
        core_lat = 10;
        base = n_starts;
        send_cmd(1, 0, 1'b1, 1, 1'b0, 1'b0);
        wait_starts(base + 1, 50);
        tick(3);
        cke = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (!busy || m_rsp_valid) ok = 1'b0;
        end
        cke = 1'b1;
        chk("cke_frozen", ok, 1);
        wait_rsp("cke", 100, 0);
        chk("cke_latency", rsp_cyc - last_start, 19);
        chk_perf("cke_perf", 11);

        // Reset mid-sequence: back to IDLE, no response beat
        core_lat = 10;
        base_d = n_dones;
        send_cmd(3, 0, 1'b0, 0, 1'b0, 1'b0);
        wait_dones(base_d + 1, 100);
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", m_rsp_valid, 0);
        chk("mid_rst_runs", m_rsp_runs, 0);
        tick(2);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (m_rsp_valid || busy || core_start) ok = 1'b0;
        end
        chk("mid_rst_quiet", ok, 1);
        chk("mid_rst_ready", s_cmd_ready, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
